prim_secded_39_32_dec_pipe: RTL and testbench

Pipelined SECDED decoder for the 39/32 Hsiao code used on 32-bit memory and bus words. It accepts 39-bit codewords through a valid/ready handshake, computes the 7-bit syndrome, corrects single-bit data errors and flags double-bit errors. It also keeps saturating error statistics and a sticky capture of the first uncorrectable syndrome. It sits on the read-return path of SRAM and register-file wrappers, in front of the consumer.

---
 rtl/prim_secded_pkg.sv | 37 +++
 rtl/prim_secded_39_32_syndrome.sv | 18 +
 rtl/prim_secded_39_32_dec_pipe.sv | 117 +++++++++++
 tb/tb_prim_secded_39_32_dec_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_secded_pkg.sv
// Shared constants for the 39/32 Hsiao SECDED code: geometry, parity masks,
// error-flag bit positions and a helper returning a data bit's H-matrix column.
package prim_secded_pkg;

    localparam int unsigned SECDED_39_32_DATA_W  = 32;
    localparam int unsigned SECDED_39_32_CHECK_W = 7;
    localparam int unsigned SECDED_39_32_CODE_W  = 39;
    localparam int unsigned SECDED_ERR_W         = 2;
    localparam int unsigned SECDED_CNT_W         = 16;

    localparam int unsigned SECDED_ERR_SINGLE = 0;
    localparam int unsigned SECDED_ERR_DOUBLE = 1;

    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M0 = 32'h318DC18C;
    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M1 = 32'hEA2AB148;
    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M2 = 32'h8CC1B6A1;
    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M3 = 32'h72C05A53;
    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M4 = 32'h4D12083D;
    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M5 = 32'h047D6456;
    localparam logic [SECDED_39_32_DATA_W-1:0] SECDED_39_32_M6 = 32'h93360FA2;

    // Index k selects the mask feeding syndrome bit k.
    localparam logic [SECDED_39_32_CHECK_W-1:0][SECDED_39_32_DATA_W-1:0] SECDED_39_32_MASKS = {
        SECDED_39_32_M6, SECDED_39_32_M5, SECDED_39_32_M4, SECDED_39_32_M3,
        SECDED_39_32_M2, SECDED_39_32_M1, SECDED_39_32_M0
    };

    function automatic logic [SECDED_39_32_CHECK_W-1:0] secded_39_32_column(input logic [4:0] bit_idx);
        logic [SECDED_39_32_CHECK_W-1:0] col;
        col = '0;
        for (int unsigned k = 0; k < SECDED_39_32_CHECK_W; k++) begin
            col[k] = SECDED_39_32_MASKS[k][bit_idx];
        end
        return col;
    endfunction

endpackage

// File: rtl/prim_secded_39_32_syndrome.sv
// Combinational 39/32 syndrome generator; shared by the read-path decoder and
// the scrubber.
module prim_secded_39_32_syndrome
    import prim_secded_pkg::*;
(
    input  logic [SECDED_39_32_CODE_W-1:0]  codeword,
    output logic [SECDED_39_32_CHECK_W-1:0] syndrome_c
);

    always_comb begin
        syndrome_c = '0;
        for (int unsigned k = 0; k < SECDED_39_32_CHECK_W; k++) begin
            syndrome_c[k] = codeword[SECDED_39_32_DATA_W + k]
                          ^ (^(codeword[SECDED_39_32_DATA_W-1:0] & SECDED_39_32_MASKS[k]));
        end
    end

endmodule

// File: rtl/prim_secded_39_32_dec_pipe.sv
// Two-stage pipelined 39/32 SECDED decoder with valid/ready flow control,
// saturating error counters and a sticky capture of the first double error.
module prim_secded_39_32_dec_pipe
    import prim_secded_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [SECDED_39_32_CODE_W-1:0]  in_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [SECDED_39_32_DATA_W-1:0]  out_data_o,
    output logic [SECDED_39_32_CHECK_W-1:0] out_syndrome_o,
    output logic [SECDED_ERR_W-1:0]         out_err_o,
    input  logic                            clr_i,
    output logic [SECDED_CNT_W-1:0]         cnt_single_o,
    output logic [SECDED_CNT_W-1:0]         cnt_double_o,
    output logic                            cap_valid_o,
    output logic [SECDED_39_32_CHECK_W-1:0] cap_syndrome_o
);

    logic                            s1_valid;
    logic [SECDED_39_32_CODE_W-1:0]  s1_code;
    logic [SECDED_39_32_CHECK_W-1:0] s1_syn;

    logic [SECDED_39_32_CHECK_W-1:0] in_syn_c;
    logic                            s2_adv_c;
    logic                            s1_adv_c;
    logic                            out_hs_c;
    logic [SECDED_39_32_DATA_W-1:0]  corr_data_c;
    logic [SECDED_ERR_W-1:0]         corr_err_c;

    prim_secded_39_32_syndrome u_syndrome (
        .codeword   (in_data_i),
        .syndrome_c (in_syn_c)
    );

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv_c   = ~out_valid_o | out_ready_i;
    assign s1_adv_c   = ~s1_valid | s2_adv_c;
    assign in_ready_o = s1_adv_c & ~rst_i;
    assign out_hs_c   = out_valid_o & out_ready_i;

    // Odd-weight syndromes are single errors; only a matching data column is flipped.
    always_comb begin
        corr_data_c = s1_code[SECDED_39_32_DATA_W-1:0];
        corr_err_c  = '0;
        if (s1_syn != '0) begin
            if (^s1_syn) begin
                corr_err_c[SECDED_ERR_SINGLE] = 1'b1;
                for (int unsigned i = 0; i < SECDED_39_32_DATA_W; i++) begin
                    if (secded_39_32_column(5'(i)) == s1_syn) begin
                        corr_data_c[i] = ~corr_data_c[i];
                    end
                end
            end else begin
                corr_err_c[SECDED_ERR_DOUBLE] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_code <= in_data_i;
                s1_syn  <= in_syn_c;
            end
        end
    end

    // Output stage holds its word untouched while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_syndrome_o <= '0;
            out_err_o      <= '0;
        end else if (s2_adv_c) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                out_data_o     <= corr_data_c;
                out_syndrome_o <= s1_syn;
                out_err_o      <= corr_err_c;
            end
        end
    end

    // Statistics advance only on a completed handoff; a clear overrides it.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_single_o   <= '0;
            cnt_double_o   <= '0;
            cap_valid_o    <= 1'b0;
            cap_syndrome_o <= '0;
        end else if (out_hs_c) begin
            if (out_err_o[SECDED_ERR_SINGLE] && (cnt_single_o != '1)) begin
                cnt_single_o <= cnt_single_o + SECDED_CNT_W'(1);
            end
            if (out_err_o[SECDED_ERR_DOUBLE]) begin
                if (cnt_double_o != '1) begin
                    cnt_double_o <= cnt_double_o + SECDED_CNT_W'(1);
                end
                if (!cap_valid_o) begin
                    cap_valid_o    <= 1'b1;
                    cap_syndrome_o <= out_syndrome_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_prim_secded_39_32_dec_pipe.sv
// Self-checking bench for the pipelined 39/32 SECDED decoder: directed code
// vectors, stall/backpressure, random traffic, counter saturation and reset.
module tb_prim_secded_39_32_dec_pipe;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [38:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [6:0]  out_syndrome_o;
    logic [1:0]  out_err_o;
    logic        clr_i;
    logic [15:0] cnt_single_o;
    logic [15:0] cnt_double_o;
    logic        cap_valid_o;
    logic [6:0]  cap_syndrome_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] masks [7] = '{32'h318DC18C, 32'hEA2AB148, 32'h8CC1B6A1, 32'h72C05A53,
                               32'h4D12083D, 32'h047D6456, 32'h93360FA2};

    int unsigned m_cs;
    int unsigned m_cd;
    logic        m_capv;
    logic [6:0]  m_caps;

    prim_secded_39_32_dec_pipe dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_syndrome_o (out_syndrome_o),
        .out_err_o      (out_err_o),
        .clr_i          (clr_i),
        .cnt_single_o   (cnt_single_o),
        .cnt_double_o   (cnt_double_o),
        .cap_valid_o    (cap_valid_o),
        .cap_syndrome_o (cap_syndrome_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // H-matrix column of data bit i, read straight off the mask table.
    function automatic logic [6:0] col(input int i);
        logic [6:0] c;
        for (int k = 0; k < 7; k++) c[k] = masks[k][i];
        return c;
    endfunction

    // Reference decode: syndrome as XOR of columns of set bits plus check bits.
    function automatic void ref_decode(input logic [38:0] cw, output logic [31:0] d,
                                       output logic [6:0] s, output logic [1:0] e);
        s = cw[38:32];
        d = cw[31:0];
        e = 2'b00;
        for (int i = 0; i < 32; i++) if (cw[i]) s ^= col(i);
        if (s != 7'd0) begin
            if (($countones(s) % 2) == 1) begin
                e = 2'b01;
                for (int i = 0; i < 32; i++) if (col(i) == s) d[i] = ~d[i];
            end else begin
                e = 2'b10;
            end
        end
    endfunction

    function automatic logic [38:0] make_word(input int nflips);
        logic [31:0] d;
        logic [6:0]  c;
        logic [38:0] w;
        int p0, p1;
        d = $urandom;
        c = 7'd0;
        for (int i = 0; i < 32; i++) if (d[i]) c ^= col(i);
        w = {c, d};
        p0 = $urandom_range(38, 0);
        if (nflips >= 1) w[p0] = ~w[p0];
        if (nflips >= 2) begin
            do p1 = $urandom_range(38, 0); while (p1 == p0);
            w[p1] = ~w[p1];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_cs = 0; m_cd = 0; m_capv = 1'b0; m_caps = 7'd0;
    endtask

    task automatic model_cnt(input logic hs, input logic [1:0] e, input logic [6:0] s, input logic clr);
        if (clr) begin
            model_reset();
        end else if (hs) begin
            if (e[0] && m_cs < 65535) m_cs++;
            if (e[1]) begin
                if (m_cd < 65535) m_cd++;
                if (!m_capv) begin m_capv = 1'b1; m_caps = s; end
            end
        end
    endtask

    // One clock of stimulus; reports what the DUT presents just before the edge.
    task automatic drive_cycle(input logic iv, input logic [38:0] cw, input logic ordy, input logic clr,
                               output logic acc, output logic ir, output logic ov, output logic hs,
                               output logic [31:0] od, output logic [6:0] os, output logic [1:0] oe);
        in_valid_i  = iv;
        in_data_i   = cw;
        out_ready_i = ordy;
        clr_i       = clr;
        #1;
        ir  = in_ready_o;
        ov  = out_valid_o;
        acc = iv & in_ready_o;
        hs  = out_valid_o & ordy;
        od  = out_data_o;
        os  = out_syndrome_o;
        oe  = out_err_o;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = make_word(0); out_ready_i = 1'b1; clr_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        checks++; if (out_data_o !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data_o); end
        checks++; if (out_syndrome_o !== 7'd0) begin errors++; $display("FAIL reset_syndrome got %h want 0", out_syndrome_o); end
        checks++; if (out_err_o !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", out_err_o); end
        checks++; if (cnt_single_o !== 16'd0) begin errors++; $display("FAIL reset_cnt_single got %h want 0", cnt_single_o); end
        checks++; if (cnt_double_o !== 16'd0) begin errors++; $display("FAIL reset_cnt_double got %h want 0", cnt_double_o); end
        checks++; if (cap_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cap_valid got %b want 0", cap_valid_o); end
        checks++; if (cap_syndrome_o !== 7'd0) begin errors++; $display("FAIL reset_cap_syndrome got %h want 0", cap_syndrome_o); end
        rst_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_directed();
        logic [38:0] cw   [5] = '{39'h41_FFFFFFFF, 39'h00_00000001, 39'h01_00000000, 39'h00_00000003, 39'h00_00000005};
        logic [31:0] xd   [5] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h3, 32'h5};
        logic [6:0]  xs   [5] = '{7'h00, 7'h1C, 7'h01, 7'h74, 7'h2D};
        logic [1:0]  xe   [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
        logic acc, ir, ov, hs;
        logic [31:0] od; logic [6:0] os; logic [1:0] oe;
        for (int v = 0; v < 5; v++) begin
            drive_cycle(1'b1, cw[v], 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got %b want 1", v, acc); end
            drive_cycle(1'b0, 39'd0, 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", v, ov); end
            drive_cycle(1'b0, 39'd0, 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
            checks++; if (hs !== 1'b1) begin errors++; $display("FAIL dir%0d_latency valid got %b want 1", v, hs); end
            checks++; if (od !== xd[v]) begin errors++; $display("FAIL dir%0d_data got %h want %h", v, od, xd[v]); end
            checks++; if (os !== xs[v]) begin errors++; $display("FAIL dir%0d_syndrome got %h want %h", v, os, xs[v]); end
            checks++; if (oe !== xe[v]) begin errors++; $display("FAIL dir%0d_err got %b want %b", v, oe, xe[v]); end
            model_cnt(1'b1, xe[v], xs[v], 1'b0);
            checks++; if (cnt_single_o !== 16'(m_cs)) begin errors++; $display("FAIL dir%0d_cnt_single got %0d want %0d", v, cnt_single_o, m_cs); end
            checks++; if (cnt_double_o !== 16'(m_cd)) begin errors++; $display("FAIL dir%0d_cnt_double got %0d want %0d", v, cnt_double_o, m_cd); end
            checks++; if (cap_valid_o !== m_capv) begin errors++; $display("FAIL dir%0d_cap_valid got %b want %b", v, cap_valid_o, m_capv); end
        end
        checks++; if (cap_syndrome_o !== 7'h74) begin errors++; $display("FAIL dir_cap_sticky got %h want 74", cap_syndrome_o); end
        drive_cycle(1'b0, 39'd0, 1'b1, 1'b1, acc, ir, ov, hs, od, os, oe);
        model_cnt(1'b0, 2'b00, 7'd0, 1'b1);
        checks++; if (cnt_single_o !== 16'd0 || cnt_double_o !== 16'd0) begin errors++; $display("FAIL dir_clr_counts got %h/%h want 0/0", cnt_single_o, cnt_double_o); end
        checks++; if (cap_valid_o !== 1'b0 || cap_syndrome_o !== 7'd0) begin errors++; $display("FAIL dir_clr_cap got %b/%h want 0/00", cap_valid_o, cap_syndrome_o); end
    endtask

    task automatic test_back_to_back();
        logic [38:0] words [8];
        logic [31:0] qd [$]; logic [6:0] qs [$]; logic [1:0] qe [$];
        logic [31:0] d; logic [6:0] s; logic [1:0] e;
        logic acc, ir, ov, hs, ordy, held_v;
        logic [31:0] od, hd; logic [6:0] os, hsyn; logic [1:0] oe, he;
        int sent, got;
        sent = 0; got = 0; held_v = 1'b0; hd = '0; hsyn = '0; he = '0;
        for (int i = 0; i < 8; i++) words[i] = make_word(i % 3);
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            ordy = !(cyc >= 3 && cyc <= 5);
            drive_cycle(sent < 8, (sent < 8) ? words[sent] : 39'd0, ordy, 1'b0, acc, ir, ov, hs, od, os, oe);
            if (cyc >= 3 && cyc <= 5) begin
                checks++; if (ir !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready cyc %0d got %b want 0", cyc, ir); end
            end
            if (held_v) begin
                checks++; if (od !== hd || os !== hsyn || oe !== he) begin errors++; $display("FAIL b2b_hold cyc %0d got %h/%h/%b want %h/%h/%b", cyc, od, os, oe, hd, hsyn, he); end
            end
            held_v = ov && !ordy; hd = od; hsyn = os; he = oe;
            if (acc) begin
                ref_decode(words[sent], d, s, e);
                qd.push_back(d); qs.push_back(s); qe.push_back(e);
                sent++;
            end
            if (hs) begin
                checks++;
                if (qd.size() == 0) begin errors++; $display("FAIL b2b_extra_word got %h want none", od); end
                else begin
                    d = qd.pop_front(); s = qs.pop_front(); e = qe.pop_front();
                    if (od !== d || os !== s || oe !== e) begin errors++; $display("FAIL b2b_word%0d got %h/%h/%b want %h/%h/%b", got, od, os, oe, d, s, e); end
                    model_cnt(1'b1, e, s, 1'b0);
                end
                got++;
            end
        end
        checks++; if (got != 8 || sent != 8) begin errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", got, sent); end
        checks++; if (cnt_single_o !== 16'(m_cs) || cnt_double_o !== 16'(m_cd)) begin errors++; $display("FAIL b2b_counts got %0d/%0d want %0d/%0d", cnt_single_o, cnt_double_o, m_cs, m_cd); end
    endtask

    task automatic test_random();
        logic [31:0] qd [$]; logic [6:0] qs [$]; logic [1:0] qe [$];
        logic [31:0] d; logic [6:0] s; logic [1:0] e;
        logic acc, ir, ov, hs, iv, ordy, clr;
        logic [31:0] od; logic [6:0] os; logic [1:0] oe;
        logic [38:0] w;
        int sent, got;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 420 && !(cyc >= 400 && qd.size() == 0); cyc++) begin
            iv   = (cyc < 400) && ($urandom_range(3, 0) != 0);
            ordy = (cyc >= 400) || ($urandom_range(3, 0) != 0);
            clr  = (cyc < 400) && ($urandom_range(49, 0) == 0);
            w    = make_word($urandom_range(2, 0));
            drive_cycle(iv, w, ordy, clr, acc, ir, ov, hs, od, os, oe);
            if (acc) begin
                ref_decode(w, d, s, e);
                qd.push_back(d); qs.push_back(s); qe.push_back(e);
                sent++;
            end
            e = 2'b00; s = 7'd0;
            if (hs) begin
                checks++;
                if (qd.size() == 0) begin errors++; $display("FAIL rnd_extra_word got %h want none", od); end
                else begin
                    d = qd.pop_front(); s = qs.pop_front(); e = qe.pop_front();
                    if (od !== d || os !== s || oe !== e) begin errors++; $display("FAIL rnd_word%0d got %h/%h/%b want %h/%h/%b", got, od, os, oe, d, s, e); end
                end
                got++;
            end
            model_cnt(hs, e, s, clr);
            checks++; if (cnt_single_o !== 16'(m_cs) || cnt_double_o !== 16'(m_cd)) begin errors++; $display("FAIL rnd_counts cyc %0d got %0d/%0d want %0d/%0d", cyc, cnt_single_o, cnt_double_o, m_cs, m_cd); end
            checks++; if (cap_valid_o !== m_capv || (m_capv && cap_syndrome_o !== m_caps)) begin errors++; $display("FAIL rnd_capture cyc %0d got %b/%h want %b/%h", cyc, cap_valid_o, cap_syndrome_o, m_capv, m_caps); end
        end
        checks++; if (qd.size() != 0 || got != sent) begin errors++; $display("FAIL rnd_drain got %0d want %0d", got, sent); end
    endtask

    // Streams n single-error words with the consumer always ready.
    task automatic stream_singles(input int n, output int got);
        logic acc, ir, ov, hs;
        logic [31:0] od; logic [6:0] os; logic [1:0] oe;
        int sent;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
            drive_cycle(sent < n, make_word(1), 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
            if (acc) sent++;
            if (hs) begin
                model_cnt(1'b1, 2'b01, os, 1'b0);
                got++;
            end
        end
    endtask

    task automatic test_saturation();
        logic acc, ir, ov, hs;
        logic [31:0] od; logic [6:0] os; logic [1:0] oe;
        int got;
        drive_cycle(1'b0, 39'd0, 1'b1, 1'b1, acc, ir, ov, hs, od, os, oe);
        model_cnt(1'b0, 2'b00, 7'd0, 1'b1);
        stream_singles(65534, got);
        checks++; if (got != 65534) begin errors++; $display("FAIL sat_preload_words got %0d want 65534", got); end
        checks++; if (cnt_single_o !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h want fffe", cnt_single_o); end
        stream_singles(3, got);
        checks++; if (cnt_single_o !== 16'hFFFF || m_cs != 65535) begin errors++; $display("FAIL sat_hold got %h want ffff", cnt_single_o); end
        // Clear lands on the same edge as a single-error handoff.
        drive_cycle(1'b1, make_word(1), 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
        drive_cycle(1'b0, 39'd0, 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
        drive_cycle(1'b0, 39'd0, 1'b1, 1'b1, acc, ir, ov, hs, od, os, oe);
        checks++; if (hs !== 1'b1 || oe !== 2'b01) begin errors++; $display("FAIL sat_clr_hs got %b/%b want 1/01", hs, oe); end
        model_cnt(hs, oe, os, 1'b1);
        checks++; if (cnt_single_o !== 16'd0 || cap_valid_o !== 1'b0) begin errors++; $display("FAIL sat_clr_wins got %h/%b want 0/0", cnt_single_o, cap_valid_o); end
        // Reset with both stages occupied.
        drive_cycle(1'b1, make_word(2), 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
        drive_cycle(1'b1, make_word(2), 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
        rst_i = 1'b1;
        drive_cycle(1'b1, make_word(2), 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
        rst_i = 1'b0;
        model_reset();
        checks++; if (ir !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %b want 0", ir); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid_o); end
        checks++; if (cnt_double_o !== 16'd0 || cap_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stats got %h/%b want 0/0", cnt_double_o, cap_valid_o); end
        drive_cycle(1'b0, 39'd0, 1'b1, 1'b0, acc, ir, ov, hs, od, os, oe);
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_s1_flushed got %b want 0", out_valid_o); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
